// File: rtl/id_pipe_stage_pkg.sv
// Shared decode definitions for the ID pipeline stage: RV32I opcodes,
// immediate format codes, ALU operation encodings and the control bundle.
package id_pipe_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd6
  } fmt_e;

  typedef struct packed {
    logic write_reg;
    logic mem_read;
    logic mem_write;
    logic src_immd;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Arithmetic ALU op: bit 3 comes from instr[30] for every R-type op, but
  // for immediates only for the shift-right group (funct3 = 101), where it
  // selects SRAI; elsewhere instr[30] is an immediate bit.
  function automatic logic [3:0] arith_alu_op(input logic [2:0] funct3,
                                              input logic       bit30,
                                              input logic       is_reg);
    return {(is_reg || (funct3 == 3'b101)) ? bit30 : 1'b0, funct3};
  endfunction

endpackage

// File: rtl/id_decode_ctrl.sv
// Combinational instruction decoder: control flags, ALU op, immediate
// format and register fields (zeroed for formats that lack them).
module id_decode_ctrl
  import id_pipe_stage_pkg::*;
#(
  parameter int REG_SEL = 5
) (
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               bit30,
  input  logic [4:0]         rd_field,
  input  logic [4:0]         rs1_field,
  input  logic [4:0]         rs2_field,
  output ctrl_t              ctrl,
  output logic [3:0]         alu_op,
  output fmt_e               fmt,
  output logic [REG_SEL-1:0] destination,
  output logic [REG_SEL-1:0] rs1,
  output logic [REG_SEL-1:0] rs2
);

  logic has_rd_s;
  logic has_rs1_s;
  logic has_rs2_s;

  // Classify the opcode and derive every decode output from it.
  always_comb begin
    ctrl      = CTRL_NONE;
    alu_op    = ALU_ADD;
    fmt       = FMT_X;
    has_rd_s  = 1'b0;
    has_rs1_s = 1'b0;
    has_rs2_s = 1'b0;
    case (opcode)
      OPC_OP: begin
        fmt       = FMT_R;
        alu_op    = arith_alu_op(funct3, bit30, 1'b1);
        has_rd_s  = 1'b1;
        has_rs1_s = 1'b1;
        has_rs2_s = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt           = FMT_I;
        alu_op        = arith_alu_op(funct3, bit30, 1'b0);
        ctrl.src_immd = 1'b1;
        has_rd_s      = 1'b1;
        has_rs1_s     = 1'b1;
      end
      OPC_LOAD: begin
        fmt           = FMT_I;
        ctrl.src_immd = 1'b1;
        ctrl.mem_read = 1'b1;
        has_rd_s      = 1'b1;
        has_rs1_s     = 1'b1;
      end
      OPC_STORE: begin
        fmt            = FMT_S;
        ctrl.src_immd  = 1'b1;
        ctrl.mem_write = 1'b1;
        has_rs1_s      = 1'b1;
        has_rs2_s      = 1'b1;
      end
      OPC_BRANCH: begin
        fmt         = FMT_B;
        alu_op      = ALU_SUB;
        ctrl.branch = 1'b1;
        has_rs1_s   = 1'b1;
        has_rs2_s   = 1'b1;
      end
      OPC_LUI: begin
        fmt           = FMT_U;
        alu_op        = ALU_PASS_B;
        ctrl.src_immd = 1'b1;
        has_rd_s      = 1'b1;
      end
      OPC_AUIPC: begin
        fmt           = FMT_U;
        ctrl.src_immd = 1'b1;
        has_rd_s      = 1'b1;
      end
      OPC_JAL: begin
        fmt       = FMT_J;
        ctrl.jump = 1'b1;
        has_rd_s  = 1'b1;
      end
      OPC_JALR: begin
        fmt           = FMT_I;
        ctrl.src_immd = 1'b1;
        ctrl.jump     = 1'b1;
        has_rd_s      = 1'b1;
        has_rs1_s     = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
    destination    = has_rd_s  ? REG_SEL'(rd_field)  : '0;
    rs1            = has_rs1_s ? REG_SEL'(rs1_field) : '0;
    rs2            = has_rs2_s ? REG_SEL'(rs2_field) : '0;
    ctrl.write_reg = has_rd_s && (destination != '0);
  end

endmodule

// File: rtl/immd_gen.sv
// Immediate generator: reassembles the sign-extended immediate for the
// given instruction format; R-type and unknown formats yield zero.
module immd_gen
  import id_pipe_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [31:7]          instr_hi,
  input  fmt_e                 fmt,
  output logic [WORD_SIZE-1:0] immd
);

  logic [31:0] imm32_s;

  // Pick and sign-extend the immediate bit fields for each format.
  always_comb begin
    imm32_s = 32'd0;
    case (fmt)
      FMT_I:   imm32_s = {{20{instr_hi[31]}}, instr_hi[31:20]};
      FMT_S:   imm32_s = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      FMT_B:   imm32_s = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                          instr_hi[30:25], instr_hi[11:8], 1'b0};
      FMT_U:   imm32_s = {instr_hi[31:12], 12'd0};
      FMT_J:   imm32_s = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                          instr_hi[20], instr_hi[30:21], 1'b0};
      default: imm32_s = 32'd0;
    endcase
  end

  assign immd = WORD_SIZE'($signed(imm32_s));

endmodule

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port; x0 is never written and always reads zero.
module regfile #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_SEL-1:0]   wsel,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [REG_SEL-1:0]   rsel1,
  input  logic [REG_SEL-1:0]   rsel2,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic [WORD_SIZE-1:0] rdata2
);

  logic [WORD_SIZE-1:0] regs_r [NUM_REGS];

  // Register write port; writes addressed to x0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (wsel != '0)) begin
      regs_r[wsel] <= wdata;
    end
  end

  assign rdata1 = regs_r[rsel1];
  assign rdata2 = regs_r[rsel2];

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction decode pipeline stage with ID/EX register, load-use hazard
// stall, flush and valid/ready handshake on both sides.
// Optional macro ID_WB_BYPASS_EN: forward same-cycle write-back data into
// data1/data2 instead of capturing the pre-write register value.
module id_pipe_stage
  import id_pipe_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic                 wb_write,
  input  logic [REG_SEL-1:0]   wb_sel,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic [WORD_SIZE-1:0] data1,
  output logic [WORD_SIZE-1:0] data2,
  output logic [WORD_SIZE-1:0] immd,
  output logic [REG_SEL-1:0]   destination,
  output logic [REG_SEL-1:0]   rs1_out,
  output logic [REG_SEL-1:0]   rs2_out,
  output logic [3:0]           alu_op,
  output logic                 write_reg,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 src_immd,
  output logic                 branch,
  output logic                 jump,
  output logic                 illegal
);

  ctrl_t                dec_ctrl_s;
  logic [3:0]           dec_alu_op_s;
  fmt_e                 dec_fmt_s;
  logic [REG_SEL-1:0]   dec_dest_s;
  logic [REG_SEL-1:0]   dec_rs1_s;
  logic [REG_SEL-1:0]   dec_rs2_s;
  logic [WORD_SIZE-1:0] dec_immd_s;
  logic [WORD_SIZE-1:0] rf_rd1_s;
  logic [WORD_SIZE-1:0] rf_rd2_s;
  logic [WORD_SIZE-1:0] op_data1_s;
  logic [WORD_SIZE-1:0] op_data2_s;
  logic                 hazard_s;
  logic                 advance_s;
  logic                 accept_s;

  logic                 out_valid_r;
  ctrl_t                ctrl_r;
  logic [3:0]           alu_op_r;
  logic [REG_SEL-1:0]   dest_r;
  logic [REG_SEL-1:0]   rs1_r;
  logic [REG_SEL-1:0]   rs2_r;
  logic [WORD_SIZE-1:0] pc_r;
  logic [WORD_SIZE-1:0] data1_r;
  logic [WORD_SIZE-1:0] data2_r;
  logic [WORD_SIZE-1:0] immd_r;

  id_decode_ctrl #(.REG_SEL(REG_SEL)) u_decode (
    .opcode      (instr[6:0]),
    .funct3      (instr[14:12]),
    .bit30       (instr[30]),
    .rd_field    (instr[11:7]),
    .rs1_field   (instr[19:15]),
    .rs2_field   (instr[24:20]),
    .ctrl        (dec_ctrl_s),
    .alu_op      (dec_alu_op_s),
    .fmt         (dec_fmt_s),
    .destination (dec_dest_s),
    .rs1         (dec_rs1_s),
    .rs2         (dec_rs2_s)
  );

  immd_gen #(.WORD_SIZE(WORD_SIZE)) u_immd (
    .instr_hi (instr[31:7]),
    .fmt      (dec_fmt_s),
    .immd     (dec_immd_s)
  );

  regfile #(.WORD_SIZE(WORD_SIZE), .NUM_REGS(NUM_REGS), .REG_SEL(REG_SEL)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_write),
    .wsel   (wb_sel),
    .wdata  (wb_data),
    .rsel1  (dec_rs1_s),
    .rsel2  (dec_rs2_s),
    .rdata1 (rf_rd1_s),
    .rdata2 (rf_rd2_s)
  );

`ifdef ID_WB_BYPASS_EN
  assign op_data1_s = (wb_write && (wb_sel != '0) && (wb_sel == dec_rs1_s)) ? wb_data : rf_rd1_s;
  assign op_data2_s = (wb_write && (wb_sel != '0) && (wb_sel == dec_rs2_s)) ? wb_data : rf_rd2_s;
`else
  assign op_data1_s = rf_rd1_s;
  assign op_data2_s = rf_rd2_s;
`endif

  // A load in ID/EX whose result an incoming source needs cannot be
  // forwarded in time, so the consumer waits one cycle. Unused source
  // fields decode to x0 and the destination is nonzero, so they never match.
  assign hazard_s  = out_valid_r && ctrl_r.mem_read && (dest_r != '0) &&
                     ((dest_r == dec_rs1_s) || (dest_r == dec_rs2_s));
  assign advance_s = !out_valid_r || out_ready;
  assign in_ready  = advance_s && !hazard_s && !flush && !rst;
  assign accept_s  = in_valid && in_ready;

  // ID/EX register: flush beats everything, then load / bubble on advance,
  // otherwise hold for the stalled execute stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      ctrl_r      <= CTRL_NONE;
      alu_op_r    <= 4'd0;
      dest_r      <= '0;
      rs1_r       <= '0;
      rs2_r       <= '0;
      pc_r        <= '0;
      data1_r     <= '0;
      data2_r     <= '0;
      immd_r      <= '0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      ctrl_r      <= CTRL_NONE;
    end else if (advance_s) begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        ctrl_r      <= dec_ctrl_s;
        alu_op_r    <= dec_alu_op_s;
        dest_r      <= dec_dest_s;
        rs1_r       <= dec_rs1_s;
        rs2_r       <= dec_rs2_s;
        pc_r        <= pc;
        data1_r     <= op_data1_s;
        data2_r     <= op_data2_s;
        immd_r      <= dec_immd_s;
      end else begin
        out_valid_r <= 1'b0;
        ctrl_r      <= CTRL_NONE;
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_pc      = pc_r;
  assign data1       = data1_r;
  assign data2       = data2_r;
  assign immd        = immd_r;
  assign destination = dest_r;
  assign rs1_out     = rs1_r;
  assign rs2_out     = rs2_r;
  assign alu_op      = alu_op_r;
  assign write_reg   = ctrl_r.write_reg;
  assign mem_read    = ctrl_r.mem_read;
  assign mem_write   = ctrl_r.mem_write;
  assign src_immd    = ctrl_r.src_immd;
  assign branch      = ctrl_r.branch;
  assign jump        = ctrl_r.jump;
  assign illegal     = ctrl_r.illegal;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios followed by
// random traffic, all compared against a behavioural stage model.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr, pc;
  logic        wb_write;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, data1, data2, immd;
  logic [4:0]  destination, rs1_out, rs2_out;
  logic [3:0]  alu_op;
  logic        write_reg, mem_read, mem_write, src_immd, branch, jump, illegal;

  id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .wb_write(wb_write), .wb_sel(wb_sel),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .data1(data1), .data2(data2),
    .immd(immd), .destination(destination), .rs1_out(rs1_out),
    .rs2_out(rs2_out), .alu_op(alu_op), .write_reg(write_reg),
    .mem_read(mem_read), .mem_write(mem_write), .src_immd(src_immd),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  dest, rs1, rs2;
    logic [3:0]  alu;
    logic        wr, mr, mw, si, br, jp, il;
    logic        has_imm, rd1, rd2;
  } stage_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] regs [32];
  stage_t      m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode built from the instruction-set rules.
  function automatic stage_t decode_ref(input logic [31:0] ins);
    stage_t s;
    logic [6:0]  op = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    logic is_r, is_ia, is_ld, is_st, is_b, is_lui, is_aui, is_jal, is_jalr, uses_rd;
    s = '{default: '0};
    is_r   = (op == 7'h33); is_ia  = (op == 7'h13); is_ld   = (op == 7'h03);
    is_st  = (op == 7'h23); is_b   = (op == 7'h63); is_lui  = (op == 7'h37);
    is_aui = (op == 7'h17); is_jal = (op == 7'h6F); is_jalr = (op == 7'h67);
    uses_rd = is_r | is_ia | is_ld | is_lui | is_aui | is_jal | is_jalr;
    s.rd1  = is_r | is_ia | is_ld | is_st | is_b | is_jalr;
    s.rd2  = is_r | is_st | is_b;
    s.dest = uses_rd ? ins[11:7]  : 5'd0;
    s.rs1  = s.rd1   ? ins[19:15] : 5'd0;
    s.rs2  = s.rd2   ? ins[24:20] : 5'd0;
    s.wr = uses_rd && (s.dest != 5'd0);
    s.mr = is_ld;
    s.mw = is_st;
    s.br = is_b;
    s.jp = is_jal | is_jalr;
    s.si = is_ia | is_ld | is_st | is_lui | is_aui | is_jalr;
    s.il = !(uses_rd | is_st | is_b);
    if (is_r)        s.alu = {ins[30], f3};
    else if (is_ia)  s.alu = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
    else if (is_b)   s.alu = 4'd8;
    else if (is_lui) s.alu = 4'd15;
    else             s.alu = 4'd0;
    s.has_imm = !is_r && !s.il;
    if (is_ia || is_ld || is_jalr) s.imm = (sx << 12) | (ins >> 20);
    else if (is_st) s.imm = (sx << 12) | ((ins >> 20) & 32'hFE0) | ((ins >> 7) & 32'h1F);
    else if (is_b)  s.imm = (sx << 12) | ((ins << 4) & 32'h800) | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
    else if (is_lui || is_aui) s.imm = ins & 32'hFFFF_F000;
    else if (is_jal) s.imm = (sx << 20) | (ins & 32'hF_F000) | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
    else s.imm = 32'd0;
    return s;
  endfunction

  function automatic logic [31:0] read_ref(input logic [4:0] idx);
`ifdef ID_WB_BYPASS_EN
    if (wb_write && (wb_sel != 5'd0) && (wb_sel == idx)) return wb_data;
`endif
    return regs[idx];
  endfunction

  function automatic stage_t kill(input stage_t s);
    stage_t k = s;
    k.valid = 1'b0; k.wr = 1'b0; k.mr = 1'b0; k.mw = 1'b0;
    k.si = 1'b0; k.br = 1'b0; k.jp = 1'b0; k.il = 1'b0;
    return k;
  endfunction

  task automatic check_out();
    chk("out_valid", out_valid, m.valid);
    chk("write_reg", write_reg, m.wr);
    chk("mem_read", mem_read, m.mr);
    chk("mem_write", mem_write, m.mw);
    chk("src_immd", src_immd, m.si);
    chk("branch", branch, m.br);
    chk("jump", jump, m.jp);
    chk("illegal", illegal, m.il);
    if (m.valid) begin
      chk("out_pc", out_pc, m.pc);
      chk("destination", destination, m.dest);
      chk("rs1_out", rs1_out, m.rs1);
      chk("rs2_out", rs2_out, m.rs2);
      chk("alu_op", alu_op, m.alu);
      if (m.rd1) chk("data1", data1, m.d1);
      if (m.rd2) chk("data2", data2, m.d2);
      if (m.has_imm) chk("immd", immd, m.imm);
    end
  endtask

  // One clock cycle: inputs already driven just after the previous edge.
  task automatic step();
    stage_t d, nx;
    logic hz, adv, rdy;
    #2;
    d   = decode_ref(instr);
    hz  = m.valid && m.mr && (m.dest != 5'd0) && ((d.rs1 == m.dest) || (d.rs2 == m.dest));
    adv = !m.valid || out_ready;
    rdy = adv && !hz && !flush;
    chk("in_ready", in_ready, rdy);
    nx = m;
    if (flush) nx = kill(m);
    else if (adv) begin
      if (in_valid && rdy) begin
        nx = d;
        nx.valid = 1'b1;
        nx.pc = pc;
        nx.d1 = read_ref(d.rs1);
        nx.d2 = read_ref(d.rs2);
      end else nx = kill(m);
    end
    if (wb_write && (wb_sel != 5'd0)) regs[wb_sel] = wb_data;
    @(posedge clk);
    #1;
    m = nx;
    check_out();
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_write = 1'b0; out_ready = 1'b1;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_in_ready"}, in_ready, 32'd0);
    chk({p, "_out_valid"}, out_valid, 32'd0);
    chk({p, "_flags"}, {write_reg, mem_read, mem_write, src_immd, branch, jump, illegal}, 32'd0);
    chk({p, "_alu_op"}, alu_op, 32'd0);
    chk({p, "_regsel"}, {destination, rs1_out, rs2_out}, 32'd0);
    chk({p, "_out_pc"}, out_pc, 32'd0);
    chk({p, "_data1"}, data1, 32'd0);
    chk({p, "_data2"}, data2, 32'd0);
    chk({p, "_immd"}, immd, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] hi = $urandom;
    logic [4:0]  rd = 5'($urandom_range(0, 7));
    logic [4:0]  a  = 5'($urandom_range(0, 7));
    logic [4:0]  b  = 5'($urandom_range(0, 7));
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0:       return {1'b0, hi[30], 5'd0, b, a, f3, rd, 7'h33};
      1:       return {hi[31:20], a, f3, rd, 7'h13};
      2:       return {hi[31:20], a, 3'b010, rd, 7'h03};
      3:       return {hi[31:25], b, a, 3'b010, hi[11:7], 7'h23};
      4:       return {hi[31:25], b, a, f3, hi[11:7], 7'h63};
      5:       return {hi[31:12], rd, 7'h37};
      6:       return {hi[31:12], rd, 7'h17};
      7:       return {hi[31:12], rd, 7'h6F};
      8:       return {hi[31:20], a, 3'b000, rd, 7'h67};
      default: return {hi[31:7], 7'h0B};
    endcase
  endfunction

  initial begin
    logic [31:0] exp_x3;
    m = '{default: '0};
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rst = 1'b1; instr = 32'd0; pc = 32'd0; wb_sel = 5'd0; wb_data = 32'd0;
    idle();

    // Reset state
    @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Give every register a known value
    for (int i = 1; i < 32; i++) begin
      wb_write = 1'b1; wb_sel = 5'(i); wb_data = $urandom;
      step();
    end
    idle();

    // ADDI x5,x0,7
    in_valid = 1'b1; instr = 32'h0070_0293; pc = 32'h100;
    step();
    chk("addi_valid", out_valid, 32'd1);
    chk("addi_dest", destination, 32'd5);
    chk("addi_immd", immd, 32'd7);
    chk("addi_src_immd", src_immd, 32'd1);
    chk("addi_write_reg", write_reg, 32'd1);
    chk("addi_alu_op", alu_op, 32'd0);

    // LW x6,0(x1) followed by dependent ADD x7,x6,x2
    instr = 32'h0000_A303; pc = 32'h104;
    step();
    instr = 32'h0023_03B3; pc = 32'h108;
    #2;
    chk("lu_stall_in_ready", in_ready, 32'd0);
    step();
    chk("lu_bubble", out_valid, 32'd0);
    #2;
    chk("lu_resume_in_ready", in_ready, 32'd1);
    step();
    chk("lu_add_valid", out_valid, 32'd1);
    chk("lu_add_rs1", rs1_out, 32'd6);
    chk("lu_add_dest", destination, 32'd7);

    // SUB x8,x1,x2 held by a stalled execute stage
    instr = 32'h4020_8433; pc = 32'h10C;
    step();
    out_ready = 1'b0; instr = 32'h0010_0493; pc = 32'h110;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("hold_in_ready", in_ready, 32'd0);
      step();
      chk("hold_alu_op", alu_op, 32'd8);
      chk("hold_dest", destination, 32'd8);
      chk("hold_pc", out_pc, 32'h10C);
    end
    out_ready = 1'b1;
    step();
    chk("hold_next_dest", destination, 32'd9);
    chk("hold_next_pc", out_pc, 32'h110);

    // Flush while a store sits in ID/EX and an ADDI is pending
    instr = 32'h0020_A223; pc = 32'h114;
    step();
    instr = 32'h0070_0293; pc = 32'h118; flush = 1'b1;
    step();
    chk("flush_valid", out_valid, 32'd0);
    chk("flush_write_reg", write_reg, 32'd0);
    chk("flush_mem_write", mem_write, 32'd0);
    flush = 1'b0;

    // Same-cycle write-back of x3 while reading x3 twice
`ifdef ID_WB_BYPASS_EN
    exp_x3 = 32'hDEAD_BEEF;
`else
    exp_x3 = regs[3];
`endif
    instr = 32'h0031_80B3; pc = 32'h11C;
    wb_write = 1'b1; wb_sel = 5'd3; wb_data = 32'hDEAD_BEEF;
    step();
    chk("wb_data1", data1, exp_x3);
    chk("wb_data2", data2, exp_x3);
    wb_write = 1'b0; pc = 32'h120;
    step();
    chk("wb_after_data1", data1, 32'hDEAD_BEEF);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_write  = ($urandom_range(0, 1) == 1);
      wb_sel    = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      instr     = rand_instr();
      pc        = $urandom & 32'hFFFF_FFFC;
      step();
    end
    idle();

    // Illegal instruction, then reset mid-stream
    in_valid = 1'b1; instr = 32'hFFFF_FFFF; pc = 32'h200;
    step();
    chk("illegal_flag", illegal, 32'd1);
    chk("illegal_write_reg", write_reg, 32'd0);
    chk("illegal_dest", destination, 32'd0);
    instr = 32'h0020_A223; pc = 32'h204;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_held");
    rst = 1'b0;
    instr = 32'h0070_0293; pc = 32'h300;
    #2;
    chk("post_rst_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", out_valid, 32'd1);
    chk("post_rst_dest", destination, 32'd5);
    chk("post_rst_pc", out_pc, 32'h300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_pipe_stage.md
ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, 32, datapath width.
REQ-002 SHALL have parameter NUM_REGS, 32, register count.
REQ-003 SHALL have parameter REG_SEL, $clog2(NUM_REGS), register select width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  instr/pc valid from fetch.
REQ-007 SHALL have port in_ready  output  1  stage accepts instr this cycle.
REQ-008 SHALL have ports instr and pc  input  WORD_SIZE  instruction and its address.
REQ-009 SHALL have ports wb_write (1), wb_sel (REG_SEL), wb_data (WORD_SIZE)  input  register write-back.
REQ-010 SHALL have port flush  input  1  kill in-flight decode (taken branch/jump).
REQ-011 SHALL have port out_valid  output  1  ID/EX register holds a valid instruction.
REQ-012 SHALL have port out_ready  input  1  execute stage accepts ID/EX contents.
REQ-013 SHALL have outputs out_pc, data1, data2, immd  WORD_SIZE; destination, rs1_out, rs2_out  REG_SEL; alu_op  4.
REQ-014 SHALL have 1-bit outputs write_reg, mem_read, mem_write, src_immd, branch, jump, illegal.

Function
REQ-015 All outputs except in_ready SHALL be registered (ID/EX register); latency one cycle from accept to out_valid.
REQ-016 Accept = in_valid && in_ready; advance = !out_valid || out_ready.
REQ-017 in_ready SHALL equal advance && !hazard && !flush.
REQ-018 hazard SHALL be: out_valid && mem_read && destination!=0 && destination matches a source the incoming instruction actually reads (rs1 for R/I/S/B/JALR, rs2 for R/S/B).
REQ-019 On advance with hazard or no accept, ID/EX SHALL load a bubble (out_valid=0, all control flags 0).
REQ-020 When !advance, ID/EX SHALL hold all contents unchanged.
REQ-021 flush SHALL clear out_valid and control flags at next edge, priority over accept, hazard and hold.
REQ-022 R-type: alu_op={instr[30],funct3}; I-arith: alu_op={funct3==101 ? instr[30] : 0, funct3}.
REQ-023 Load, store, JALR, AUIPC SHALL use alu_op 0000 (ADD); branch 1000 (SUB); LUI 1111 (pass B).
REQ-024 src_immd SHALL be 1 for I-arith, load, store, LUI, AUIPC, JALR; 0 otherwise.
REQ-025 mem_read=load; mem_write=store; branch=B-type; jump=JAL or JALR.
REQ-026 write_reg SHALL be 1 for R, I-arith, load, LUI, AUIPC, JAL, JALR when destination!=0; else 0.
REQ-027 Unrecognised opcode SHALL set illegal=1 with all other control flags 0 and destination=0.
REQ-028 destination, rs1_out, rs2_out SHALL be 0 for formats lacking that field.
REQ-029 Register reads SHALL be combinational from the register file in the accept cycle; writes to x0 ignored.

Reset
REQ-030 rst SHALL asynchronously clear out_valid, all control flags, alu_op, destination, rs1_out, rs2_out, out_pc, data1, data2, immd to 0.
REQ-031 in_ready SHALL be 0 while rst is high; first accept possible on first edge after deassertion.

Configuration
REQ-032 Macro ID_WB_BYPASS_EN defined: when wb_write && wb_sel!=0 && wb_sel equals rs1/rs2 in the accept cycle, data1/data2 SHALL capture wb_data.
REQ-033 Macro ID_WB_BYPASS_EN undefined: data1/data2 SHALL capture the pre-write register value; upstream must separate dependent instructions.

Structure
REQ-034 Opcode constants, format codes and alu_op encodings SHALL live in the shared defines.vh package.
REQ-035 Combinational decode SHALL be a sub-module id_decode_ctrl; existing regfile and immd_gen SHALL be instantiated unchanged.

Verification
REQ-036 ADDI x5,x0,7 (0x00700293) accepted -> next cycle out_valid=1, destination=5, immd=7, src_immd=1, write_reg=1, alu_op=0000.
REQ-037 LW x6,0(x1) then ADD x7,x6,x2 back-to-back -> in_ready=0 one cycle, one bubble, ADD issues the following cycle with rs1_out=6.
REQ-038 out_ready=0 for 3 cycles with valid SUB held -> ID/EX contents unchanged, in_ready=0, no instruction lost.
REQ-039 flush asserted with valid instr pending -> next cycle out_valid=0, write_reg=0, mem_write=0.
REQ-040 wb_write=1, wb_sel=3, wb_data=0xDEADBEEF while accepting ADD x1,x3,x3 -> data1=data2=0xDEADBEEF with ID_WB_BYPASS_EN, old x3 value without.
REQ-041 instr=0xFFFFFFFF, then rst asserted mid-stream -> illegal=1, write_reg=0; after rst all outputs 0 immediately.
